ysyx_24090012_wb_arbiter: RTL and testbench

Shares the register file's single write port between the EXU and LSU writeback paths. It also keeps a per-register busy scoreboard that holds decode off on RAW/WAW hazards. It sits between IDU/EXU/LSU and `ysyx_24090012_RegisterFile`, and drives that module's `wen`/`waddr`/`wdata`/`pc` inputs from registered outputs.

---
 rtl/ysyx_24090012_wb_pkg.sv | 7 +
 rtl/ysyx_24090012_scoreboard.sv | 27 ++
 rtl/ysyx_24090012_wb_arbiter.sv | 107 ++++++++++
 tb/tb_ysyx_24090012_wb_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24090012_wb_pkg.sv
// ysyx_24090012_wb_pkg: shared types and default widths for the writeback arbiter
package ysyx_24090012_wb_pkg;
   typedef enum logic {WB_EXU = 1'b0, WB_LSU = 1'b1} wb_src_e;
   localparam int NUM_WB_SRC    = 2;
   localparam int WB_ADDR_WIDTH = 5;
   localparam int WB_DATA_WIDTH = 32;
endpackage

// File: rtl/ysyx_24090012_scoreboard.sv
// ysyx_24090012_scoreboard: per-register busy bits, set wins over clear, bit 0 hardwired to 0
module ysyx_24090012_scoreboard
   import ysyx_24090012_wb_pkg::*;
#(
   parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       set_en_i,
   input  logic [ADDR_WIDTH-1:0]      set_idx_i,
   input  logic                       clr_en_i,
   input  logic [ADDR_WIDTH-1:0]      clr_idx_i,
   output logic [2**ADDR_WIDTH-1:0]   busy_o
);
   logic [2**ADDR_WIDTH-1:0] busy_q, busy_d;
   always_comb begin
      busy_d = busy_q;
      if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
      if (set_en_i) busy_d[set_idx_i] = 1'b1;
      busy_d[0] = 1'b0;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy_q <= '0;
      else      busy_q <= busy_d;
   end
   assign busy_o = busy_q;
endmodule

// File: rtl/ysyx_24090012_wb_arbiter.sv
// ysyx_24090012_wb_arbiter: round-robin EXU/LSU writeback arbiter with busy scoreboard.
// Define YSYX_24090012_SB_CHECK_EN to compile in the sticky scoreboard protocol checker.
module ysyx_24090012_wb_arbiter
   import ysyx_24090012_wb_pkg::*;
#(
   parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
   parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dec_valid,
   input  logic [ADDR_WIDTH-1:0]    dec_rs1,
   input  logic [ADDR_WIDTH-1:0]    dec_rs2,
   input  logic [ADDR_WIDTH-1:0]    dec_rd,
   input  logic                     dec_rd_wen,
   output logic                     dec_ready,
   input  logic                     exu_valid,
   input  logic [ADDR_WIDTH-1:0]    exu_rd,
   input  logic [DATA_WIDTH-1:0]    exu_data,
   input  logic [31:0]              exu_pc,
   output logic                     exu_ready,
   input  logic                     lsu_valid,
   input  logic [ADDR_WIDTH-1:0]    lsu_rd,
   input  logic [DATA_WIDTH-1:0]    lsu_data,
   input  logic [31:0]              lsu_pc,
   output logic                     lsu_ready,
   output logic                     rf_wen,
   output logic [ADDR_WIDTH-1:0]    rf_waddr,
   output logic [DATA_WIDTH-1:0]    rf_wdata,
   output logic [31:0]              rf_pc,
   output logic [2**ADDR_WIDTH-1:0] sb_busy,
   output logic                     sb_err
);
   wb_src_e                prio_q, prio_d;
   logic                   rf_wen_q, rf_wen_d;
   logic [ADDR_WIDTH-1:0]  rf_waddr_q, g_rd;
   logic [DATA_WIDTH-1:0]  rf_wdata_q, g_data;
   logic [31:0]            rf_pc_q, g_pc;
   logic                   any_grant, set_en;
   logic [2**ADDR_WIDTH-1:0] busy;

   assign dec_ready = !(busy[dec_rs1] || busy[dec_rs2] || (dec_rd_wen && busy[dec_rd]));
   assign set_en    = dec_valid && dec_ready && dec_rd_wen && (dec_rd != '0);

   ysyx_24090012_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
      .clk       (clk),
      .rst       (rst),
      .set_en_i  (set_en),
      .set_idx_i (dec_rd),
      .clr_en_i  (rf_wen_q),
      .clr_idx_i (rf_waddr_q),
      .busy_o    (busy)
   );

   always_comb begin
      exu_ready = exu_valid && (!lsu_valid || prio_q == WB_EXU);
      lsu_ready = lsu_valid && (!exu_valid || prio_q == WB_LSU);
      any_grant = exu_valid || lsu_valid;
      g_rd      = exu_ready ? exu_rd   : lsu_rd;
      g_data    = exu_ready ? exu_data : lsu_data;
      g_pc      = exu_ready ? exu_pc   : lsu_pc;
      rf_wen_d  = any_grant && (g_rd != '0);
      prio_d    = (exu_valid && lsu_valid) ? ((prio_q == WB_EXU) ? WB_LSU : WB_EXU) : prio_q;
   end

   // Address/data/pc hold when idle; only the enable drops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prio_q     <= WB_EXU;
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         rf_pc_q    <= '0;
      end else begin
         prio_q   <= prio_d;
         rf_wen_q <= rf_wen_d;
         if (any_grant) begin
            rf_waddr_q <= g_rd;
            rf_wdata_q <= g_data;
            rf_pc_q    <= g_pc;
         end
      end
   end

   assign rf_wen   = rf_wen_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign rf_pc    = rf_pc_q;
   assign sb_busy  = busy;

`ifdef YSYX_24090012_SB_CHECK_EN
   logic err_q, bad_wb, bad_set;
   assign bad_wb  = any_grant && (g_rd != '0) && !busy[g_rd];
   assign bad_set = set_en && busy[dec_rd];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else begin
         if (bad_wb || bad_set) err_q <= 1'b1;
         if (bad_wb) $display("[SB] %0t writeback to idle rd %0d pc %h", $time, g_rd, g_pc);
         if (bad_set) $display("[SB] %0t issue re-sets busy rd %0d pc %h", $time, dec_rd, rf_pc_q);
      end
   end
   assign sb_err = err_q;
`else
   assign sb_err = 1'b0;
`endif
endmodule

// File: tb/tb_ysyx_24090012_wb_arbiter.sv
// tb_ysyx_24090012_wb_arbiter: directed and randomized checks against a behavioural model
module tb_ysyx_24090012_wb_arbiter;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 2**AW;

   logic clk = 1'b0;
   logic rst;
   logic dec_valid, dec_rd_wen, dec_ready;
   logic [AW-1:0] dec_rs1, dec_rs2, dec_rd;
   logic exu_valid, exu_ready, lsu_valid, lsu_ready;
   logic [AW-1:0] exu_rd, lsu_rd;
   logic [DW-1:0] exu_data, lsu_data;
   logic [31:0] exu_pc, lsu_pc;
   logic rf_wen, sb_err;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [31:0] rf_pc;
   logic [NR-1:0] sb_busy;

   int n_tests = 0;
   int n_fail  = 0;

   bit m_busy[NR];
   bit m_prio, m_wen, m_err;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   logic [31:0] m_pc;

   always #5 clk = ~clk;

   ysyx_24090012_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
      .dec_rd_wen(dec_rd_wen), .dec_ready(dec_ready),
      .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_pc(exu_pc), .exu_ready(exu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_pc(lsu_pc), .lsu_ready(lsu_ready),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_pc(rf_pc),
      .sb_busy(sb_busy), .sb_err(sb_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [NR-1:0] busy_vec();
      logic [NR-1:0] v;
      for (int i = 0; i < NR; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      m_prio = 1'b0; m_wen = 1'b0; m_err = 1'b0;
      m_waddr = '0; m_wdata = '0; m_pc = '0;
   endtask

   task automatic idle();
      dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_rd_wen = 0;
      exu_valid = 0; exu_rd = 0; exu_data = 0; exu_pc = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0; lsu_pc = 0;
   endtask

   task automatic rand_inputs(input int maxreg);
      dec_valid  = 1'($urandom_range(0, 1));
      dec_rs1    = AW'($urandom_range(0, maxreg));
      dec_rs2    = AW'($urandom_range(0, maxreg));
      dec_rd     = AW'($urandom_range(0, maxreg));
      dec_rd_wen = 1'($urandom_range(0, 1));
      exu_valid  = 1'($urandom_range(0, 1));
      exu_rd     = AW'($urandom_range(0, maxreg));
      exu_data   = $urandom;
      exu_pc     = $urandom;
      lsu_valid  = 1'($urandom_range(0, 1));
      lsu_rd     = AW'($urandom_range(0, maxreg));
      lsu_data   = $urandom;
      lsu_pc     = $urandom;
   endtask

   // One cycle: check the combinational readies, advance the model across the edge, check state.
   task automatic step();
      bit exp_rdy, eg, lg, set;
      logic [AW-1:0] grd;
      logic [DW-1:0] gd;
      logic [31:0] gp;
      exp_rdy = !(m_busy[dec_rs1] || m_busy[dec_rs2] || (dec_rd_wen && m_busy[dec_rd]));
      eg = exu_valid && (!lsu_valid || !m_prio);
      lg = lsu_valid && !eg;
      #1;
      chk("dec_ready", dec_ready, exp_rdy);
      chk("exu_ready", exu_ready, eg);
      chk("lsu_ready", lsu_ready, lg);
      set = dec_valid && exp_rdy && dec_rd_wen && dec_rd != 0;
      grd = eg ? exu_rd : lsu_rd;
      gd  = eg ? exu_data : lsu_data;
      gp  = eg ? exu_pc : lsu_pc;
`ifdef YSYX_24090012_SB_CHECK_EN
      if ((eg || lg) && grd != 0 && !m_busy[grd]) m_err = 1'b1;
      if (set && m_busy[dec_rd]) m_err = 1'b1;
`endif
      @(posedge clk);
      if (m_wen) m_busy[m_waddr] = 1'b0;
      if (set) m_busy[dec_rd] = 1'b1;
      if (eg || lg) begin
         m_wen = (grd != 0); m_waddr = grd; m_wdata = gd; m_pc = gp;
      end else m_wen = 1'b0;
      if (exu_valid && lsu_valid) m_prio = !m_prio;
      #1;
      chk("rf_wen", rf_wen, m_wen);
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
      chk("rf_pc", rf_pc, m_pc);
      chk("sb_busy", sb_busy, busy_vec());
      chk("sb_err", sb_err, m_err);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_inputs(NR - 1);
         @(posedge clk); #1;
      end
      chk("rst_rf_wen", rf_wen, 0);
      chk("rst_sb_busy", sb_busy, 0);
      chk("rst_sb_err", sb_err, 0);
      idle();
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      do_reset();
      dec_valid = 1;
      step();

      // RAW stall on x5 followed by its writeback
      idle(); dec_valid = 1; dec_rd = 5; dec_rd_wen = 1; step();
      chk("raw_busy5", sb_busy[5], 1);
      idle(); dec_valid = 1; dec_rs1 = 5; #1;
      chk("raw_stall", dec_ready, 0);
      step();
      idle(); dec_valid = 1; dec_rs1 = 5; exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF; exu_pc = 32'h8000_0010;
      step();
      chk("raw_wdata", rf_wdata, 32'hDEADBEEF);
      chk("raw_waddr", rf_waddr, 5);
      idle(); dec_valid = 1; dec_rs1 = 5; step();
      idle(); dec_valid = 1; dec_rs1 = 5; #1;
      chk("raw_release", dec_ready, 1);
      step();

      // Contention: strict alternation starting with EXU
      do_reset();
      for (int i = 0; i < 6; i++) begin
         exu_valid = 1; exu_rd = 1; exu_data = i; exu_pc = 32'h100 + i;
         lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hF0 + i; lsu_pc = 32'h200 + i;
         #1;
         chk("cont_exu_first", exu_ready, (i % 2) == 0);
         step();
         chk("cont_waddr", rf_waddr, (i % 2) == 0 ? 1 : 2);
      end

      // Index 0 is accepted and dropped
      idle(); dec_valid = 1; dec_rd = 0; dec_rd_wen = 1; step();
      idle(); lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234; step();
      chk("idx0_wen", rf_wen, 0);
      idle(); step();

      // Writeback to an idle register (error when checker compiled in), stays sticky
      idle(); exu_valid = 1; exu_rd = 7; exu_data = 32'h77; step();
      idle(); step(); step();

      // Mid-operation asynchronous reset with x3 busy and a write pending
      do_reset();
      idle(); exu_valid = 1; lsu_valid = 1; exu_rd = 1; lsu_rd = 2; step();
      idle(); dec_valid = 1; dec_rd = 3; dec_rd_wen = 1; exu_valid = 1; exu_rd = 9; step();
      chk("mid_busy3", sb_busy[3], 1);
      chk("mid_wen", rf_wen, 1);
      idle(); exu_valid = 1; lsu_valid = 1;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_wen", rf_wen, 0);
      chk("mid_rst_busy", sb_busy, 0);
      chk("mid_rst_prio", exu_ready, 1);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      step();

      // Randomized traffic, narrow register range to force hazards
      for (int i = 0; i < 400; i++) begin
         rand_inputs(7);
         step();
      end
      idle();
      for (int i = 0; i < 4; i++) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
